regfile_mp: RTL

//  Parametrised general-purpose register file for the CPU datapath: two async read ports,
//  one sync write port with half-word/link/clear write modes, optional write-to-read bypass,
//  and a per-register pending scoreboard for hazard stalls. Sits between decode and ALU.
//  The datapath writes back into it and the PC unit feeds the link value.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_merge.sv | 45 ++++
 rtl/regfile_mp.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: write-mode encodings and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 16;

  // Encodings 101-111 are deliberately left out: they behave as NOP.
  typedef enum logic [2:0] {
    WM_FULL = 3'b000,
    WM_LO   = 3'b001,
    WM_HI   = 3'b010,
    WM_LINK = 3'b011,
    WM_CLR  = 3'b100
  } wr_mode_e;

  // True for every encoding that updates a register.
  function automatic logic mode_writes(input logic [2:0] m);
    return (m <= WM_CLR);
  endfunction

endpackage

// File: rtl/regfile_merge.sv
// Write-merge unit: resolves write target, merged post-edge value and write-valid.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs every cycle.
//   mode/wr_addr/wr_data/pc : write request from the datapath and PC unit
//   cur                     : current contents of the resolved target register
//   tgt/merged/wvld         : target index, value after the edge, write takes effect
module regfile_merge
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AW       = 4,
  parameter int LINK_REG = 15,
  parameter int ZERO_REG = 0
) (
  input  logic [2:0]        mode,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] cur,
  output logic [AW-1:0]     tgt,
  output logic [DATA_W-1:0] merged,
  output logic              wvld
);

  localparam int            H      = DATA_W / 2;
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  // The target must not depend on cur: the parent indexes the register array with
  // tgt and feeds the result back as cur, so keep these as separate assigns.
  assign tgt  = (mode == WM_LINK) ? LINK_A : wr_addr;
  assign wvld = mode_writes(mode) && !((ZERO_REG != 0) && (tgt == '0));

  always_comb begin
    merged = '0;
    case (mode)
      WM_FULL: merged = wr_data;
      WM_LO:   merged = {cur[DATA_W-1:H], wr_data[H-1:0]};
      // The low half of the data lands in the upper half of the register.
      WM_HI:   merged = {wr_data[H-1:0], cur[H-1:0]};
      WM_LINK: merged = pc;
      default: merged = '0;  // CLR, and don't-care for NOP (wvld is low)
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Register file: 2 async read ports, 1 sync merged-write port, bypass, pending scoreboard.
// Latency: reads combinational (optional same-cycle forward); writes/pending update in 1 edge.
// Backpressure: none; consumers stall on busy_a/busy_b.
//   rd_addr_a/b -> rd_data_a/b, busy_a/b : read ports and their pending bits
//   wr_addr/wr_data/wr_mode/pc           : write port (LINK stores pc into LINK_REG)
//   rsv_en/rsv_addr                      : mark a register pending when its producer issues
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int LINK_REG = 15,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        wr_mode,
  input  logic [DATA_W-1:0] pc,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic              busy_a,
  output logic              busy_b
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_nxt;

  logic [AW-1:0]     wr_tgt;
  logic [DATA_W-1:0] wr_mrg;
  logic              wr_vld;
  logic              rsv_ok;
  logic              byp_a;
  logic              byp_b;

  // Single merge instance shared by the write path and the bypass.
  regfile_merge #(
    .DATA_W  (DATA_W),
    .AW      (AW),
    .LINK_REG(LINK_REG),
    .ZERO_REG(ZERO_REG)
  ) u_merge (
    .mode   (wr_mode),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .pc     (pc),
    .cur    (regs[wr_tgt]),
    .tgt    (wr_tgt),
    .merged (wr_mrg),
    .wvld   (wr_vld)
  );

  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Write completion clears first, a reservation then sets: a new producer
  // issued in the same cycle as the old one retires keeps the register pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_vld) pend_nxt[wr_tgt] = 1'b0;
    if (rsv_ok) pend_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (wr_vld) regs[wr_tgt] <= wr_mrg;
      pend <= pend_nxt;
    end
  end

  // Forwarding is suppressed in reset so reads see the cleared array, not a
  // write that will be discarded.
  assign byp_a = (BYPASS != 0) && rst_n && wr_vld && (wr_tgt == rd_addr_a);
  assign byp_b = (BYPASS != 0) && rst_n && wr_vld && (wr_tgt == rd_addr_b);

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) rd_data_a = '0;
    if (byp_a) rd_data_a = wr_mrg;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) rd_data_b = '0;
    if (byp_b) rd_data_b = wr_mrg;
  end

  // A forwarded value is already available, so the consumer need not stall.
  assign busy_a = pend[rd_addr_a] & ~byp_a;
  assign busy_b = pend[rd_addr_b] & ~byp_b;

endmodule
